// File: rtl/dp_tx_sdp_crc_extract.sv
`default_nettype none
// ============================================================================
// Module : dp_tx_sdp_crc_extract
// Brief  : Parses the SDP word stream, captures the reference CRC from CRC-type
//          packets and presents it per frame to the Profile 0 CRC checker.
// Rev    : 1.0  initial release
// ============================================================================
module dp_tx_sdp_crc_extract #(
    parameter logic [7:0] CRC_SDP_TYPE = 8'h06,
    parameter int         PKT_WORDS    = 9,
    parameter int         CRC_WORD_IDX = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sdp_valid,
    input  logic [31:0] sdp_data,
    input  logic        sdp_sop,
    input  logic        sdp_eop,
    input  logic        frame_start,
    output logic [31:0] sdp_crc,
    output logic        sdp_crc_stale,
    output logic        sdp_pkt_err,
    output logic [7:0]  sdp_err_cnt
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_payload = 2'd1;
    localparam logic [1:0] c_st_skip    = 2'd2;
    localparam logic [3:0] c_last_idx   = 4'(PKT_WORDS - 1);
    localparam logic [3:0] c_crc_idx    = 4'(CRC_WORD_IDX);

    logic [1:0]  r_state;
    logic [3:0]  r_wcnt;
    logic [31:0] r_cap;
    logic [31:0] r_pend;
    logic        r_pend_vld;

    logic        w_hdr;
    logic        w_is_crc;
    logic        w_in_pay;
    logic        w_at_last;
    logic        w_commit;
    logic        w_err;
    logic [31:0] w_crc_word;

    always_comb begin
        // A valid sop is always a header, whatever state the parser is in.
        w_hdr      = sdp_valid & sdp_sop;
        w_is_crc   = (sdp_data[15:8] == CRC_SDP_TYPE);
        w_in_pay   = sdp_valid & ~sdp_sop & (r_state == c_st_payload);
        w_at_last  = (r_wcnt == c_last_idx);
        w_commit   = w_in_pay & sdp_eop & w_at_last;
        // Short (eop early) and long (last word without eop) both show as a mismatch.
        w_err      = (w_hdr & w_is_crc & sdp_eop)
                   | (w_hdr & (r_state == c_st_payload))
                   | (w_in_pay & (sdp_eop ^ w_at_last));
        w_crc_word = (w_in_pay && (r_wcnt == c_crc_idx)) ? sdp_data : r_cap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_wcnt        <= 4'd0;
            r_cap         <= 32'd0;
            r_pend        <= 32'd0;
            r_pend_vld    <= 1'b0;
            sdp_crc       <= 32'd0;
            sdp_crc_stale <= 1'b0;
            sdp_pkt_err   <= 1'b0;
            sdp_err_cnt   <= 8'd0;
        end else begin
            if (w_hdr) begin
                r_wcnt <= 4'd1;
                if (!sdp_eop)
                    r_state <= w_is_crc ? c_st_payload : c_st_skip;
                else
                    r_state <= c_st_idle;
            end else if (w_in_pay) begin
                r_wcnt <= r_wcnt + 4'd1;
                if (r_wcnt == c_crc_idx)
                    r_cap <= sdp_data;
                if (sdp_eop)
                    r_state <= c_st_idle;
                else if (w_at_last)
                    r_state <= c_st_skip;
            end else if (sdp_valid && sdp_eop && (r_state == c_st_skip)) begin
                r_state <= c_st_idle;
            end

            sdp_pkt_err <= w_err;
            if (w_err && (sdp_err_cnt != 8'hFF))
                sdp_err_cnt <= sdp_err_cnt + 8'd1;

            sdp_crc_stale <= 1'b0;
            if (frame_start) begin
                // A commit in the same cycle bypasses the pending register.
                if (w_commit) begin
                    sdp_crc    <= w_crc_word;
                    r_pend_vld <= 1'b0;
                end else if (r_pend_vld) begin
                    sdp_crc    <= r_pend;
                    r_pend_vld <= 1'b0;
                end else begin
                    sdp_crc_stale <= 1'b1;
                end
            end else if (w_commit) begin
                r_pend     <= w_crc_word;
                r_pend_vld <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
